// File: rtl/imem_cache.sv
// Direct-mapped instruction cache, one 32-bit word per line, single outstanding fill.
// Define ICACHE_STATS_EN to build the saturating hit/miss counters; otherwise they read 0.
//
// state | meaning
// IDLE  | serve hits combinationally; a miss latches the fetch address
// FILL  | mem_rd held on latched address until mem_ready, then line written
module imem_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  output logic [31:0] cpu_data,
  output logic        cpu_ready,
  input  logic        flush,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_data,
  input  logic        mem_ready,
  output logic [15:0] hit_count,
  output logic [15:0] miss_count
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 14 - INDEX_BITS;

  typedef enum logic {IDLE, FILL} state_t;

  state_t                state_q, state_d;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q [LINES];
  logic [31:0]           data_q [LINES];
  logic [15:0]           fill_addr_q;
  logic                  flush_pend_q;
  logic                  fill_write;
  logic                  miss_take;

  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;

  assign req_idx  = cpu_addr[INDEX_BITS+1:2];
  assign req_tag  = cpu_addr[15:INDEX_BITS+2];
  assign fill_idx = fill_addr_q[INDEX_BITS+1:2];
  assign fill_tag = fill_addr_q[15:INDEX_BITS+2];

  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b0;
    cpu_data   = '0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    fill_write = 1'b0;
    miss_take  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req && !flush) begin
          if (valid_q[req_idx] && (tag_q[req_idx] == req_tag)) begin
            cpu_ready = 1'b1;
            cpu_data  = data_q[req_idx];
          end else begin
            miss_take = 1'b1;
            state_d   = FILL;
          end
        end
      end
      FILL: begin
        mem_rd   = 1'b1;
        mem_addr = fill_addr_q;
        if (mem_ready) begin
          // a flush seen at any point of the fill poisons the returning word
          fill_write = !flush && !flush_pend_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      fill_addr_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (miss_take) begin
        fill_addr_q  <= cpu_addr & 16'hFFFC;
        flush_pend_q <= 1'b0;
      end else if (state_q == FILL && flush) begin
        flush_pend_q <= 1'b1;
      end
      if (flush) begin
        valid_q <= '0;
      end else if (fill_write) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fill_write) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_data;
    end
  end

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (cpu_ready && hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
      if (miss_take && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_imem_cache.sv
// Directed self-checking bench for imem_cache (INDEX_BITS=4); expectations follow ICACHE_STATS_EN.
module tb_imem_cache;

`ifdef ICACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic        flush = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] cpu_data;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] hit_count, miss_count;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;
  logic [15:0] exp_h, exp_m;

  imem_cache #(.INDEX_BITS(4)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_data(cpu_data), .cpu_ready(cpu_ready), .flush(flush),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ready(mem_ready),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  // Drives a memory response after lat FILL cycles; records what was seen during the fill.
  task automatic run_fill(input logic [15:0] addr, input logic [31:0] data, input int lat,
                          output int rd, output int rdy, output int bad);
    rd = 0; rdy = 0; bad = 0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      mem_ready = (i == lat - 1);
      mem_data  = (i == lat - 1) ? data : 32'h0;
      #1;
      if (mem_rd) rd++;
      if (cpu_ready) rdy++;
      if (mem_addr !== addr) bad++;
    end
    @(negedge clk);
    mem_ready = 1'b0;
    mem_data  = '0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", cpu_ready); end
    checks++; if (cpu_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", cpu_data); end
    checks++; if (mem_rd !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem: got rd=%b addr=%h want 0/0", mem_rd, mem_addr); end
    checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin errors++; $display("FAIL reset_counts: got %h/%h want 0/0", hit_count, miss_count); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_miss_fill();
    int rd, rdy, bad;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0040;
    #1;
    checks++; if (cpu_ready !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL miss_cycle: got ready=%b rd=%b want 0/0", cpu_ready, mem_rd); end
    run_fill(16'h0040, 32'h00500093, 3, rd, rdy, bad);
    exp_miss = 1;
    checks++; if (rd !== 3) begin errors++; $display("FAIL fill_rd_cycles: got %0d want 3", rd); end
    checks++; if (rdy !== 0) begin errors++; $display("FAIL ready_in_fill: got %0d want 0", rdy); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL fill_addr: got %0d bad cycles want 0", bad); end
    checks++; if (cpu_ready !== 1'b1 || cpu_data !== 32'h00500093) begin errors++; $display("FAIL post_fill_hit: got %b/%h want 1/00500093", cpu_ready, cpu_data); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL post_fill_rd: got %b want 0", mem_rd); end
    exp_m = STATS ? 16'(exp_miss) : 16'h0;
    checks++; if (miss_count !== exp_m || hit_count !== 16'h0) begin errors++; $display("FAIL miss_count_1: got %h/%h want %h/0", miss_count, hit_count, exp_m); end
  endtask

  task automatic test_hit();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      exp_hits = i;
      exp_h = STATS ? 16'(exp_hits) : 16'h0;
      checks++; if (cpu_ready !== 1'b1 || cpu_data !== 32'h00500093 || mem_rd !== 1'b0) begin errors++; $display("FAIL hit_hold: got %b/%h rd=%b want 1/00500093 rd=0", cpu_ready, cpu_data, mem_rd); end
      checks++; if (hit_count !== exp_h) begin errors++; $display("FAIL hit_count_step: got %h want %h", hit_count, exp_h); end
    end
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    exp_hits = 5;
    exp_h = STATS ? 16'(exp_hits) : 16'h0;
    checks++; if (cpu_ready !== 1'b0 || cpu_data !== 32'h0 || mem_rd !== 1'b0 || mem_addr !== 16'h0) begin errors++; $display("FAIL no_req_outputs: got %b/%h rd=%b addr=%h want all 0", cpu_ready, cpu_data, mem_rd, mem_addr); end
    checks++; if (hit_count !== exp_h) begin errors++; $display("FAIL hit_count_5: got %h want %h", hit_count, exp_h); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0043;
    #1;
    checks++; if (cpu_ready !== 1'b1 || cpu_data !== 32'h00500093) begin errors++; $display("FAIL byte_offset_hit: got %b/%h want 1/00500093", cpu_ready, cpu_data); end
    @(negedge clk);
    cpu_req = 1'b0;
    exp_hits = 6;
  endtask

  task automatic test_conflict();
    int rd, rdy, bad;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0080;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL conflict_miss: got %b want 0", cpu_ready); end
    run_fill(16'h0080, 32'hDEADBEEF, 1, rd, rdy, bad);
    exp_miss = 2;
    checks++; if (rd !== 1 || bad !== 0 || cpu_ready !== 1'b1 || cpu_data !== 32'hDEADBEEF) begin errors++; $display("FAIL conflict_fill: got rd=%0d bad=%0d %b/%h want 1/0 1/deadbeef", rd, bad, cpu_ready, cpu_data); end
    @(negedge clk);
    cpu_addr = 16'h0040;
    exp_hits = 7;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL evicted_miss: got %b want 0", cpu_ready); end
    run_fill(16'h0040, 32'h00500093, 2, rd, rdy, bad);
    exp_miss = 3;
    checks++; if (rd !== 2 || bad !== 0 || cpu_ready !== 1'b1 || cpu_data !== 32'h00500093) begin errors++; $display("FAIL refill: got rd=%0d bad=%0d %b/%h want 2/0 1/00500093", rd, bad, cpu_ready, cpu_data); end
    @(negedge clk);
    cpu_req = 1'b0;
    exp_hits = 8;
    #1;
    exp_h = STATS ? 16'(exp_hits) : 16'h0;
    exp_m = STATS ? 16'(exp_miss) : 16'h0;
    checks++; if (hit_count !== exp_h || miss_count !== exp_m) begin errors++; $display("FAIL conflict_counts: got %h/%h want %h/%h", hit_count, miss_count, exp_h, exp_m); end
  endtask

  task automatic test_flush();
    int rd, rdy, bad;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    #1;
    exp_miss = 4;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL flush_fill_start: got %b want 0", cpu_ready); end
    @(negedge clk);
    flush = 1'b1;
    #1;
    checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0100 || cpu_ready !== 1'b0) begin errors++; $display("FAIL flush_in_fill: got rd=%b addr=%h ready=%b want 1/0100/0", mem_rd, mem_addr, cpu_ready); end
    @(negedge clk);
    flush = 1'b0;
    #1;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL fill_survives_flush: got %b want 1", mem_rd); end
    @(negedge clk);
    mem_ready = 1'b1; mem_data = 32'hCAFEF00D;
    @(negedge clk);
    mem_ready = 1'b0; mem_data = '0;
    #1;
    exp_miss = 5;
    checks++; if (cpu_ready !== 1'b0 || mem_rd !== 1'b0) begin errors++; $display("FAIL flushed_line_invalid: got ready=%b rd=%b want 0/0", cpu_ready, mem_rd); end
    @(negedge clk);
    flush = 1'b1; mem_ready = 1'b1; mem_data = 32'hCAFEF00D;
    #1;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL second_fill_rd: got %b want 1", mem_rd); end
    @(negedge clk);
    flush = 1'b0; mem_ready = 1'b0; mem_data = '0;
    #1;
    exp_miss = 6;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL flush_with_ready: got %b want 0", cpu_ready); end
    run_fill(16'h0100, 32'hCAFEF00D, 1, rd, rdy, bad);
    checks++; if (rd !== 1 || cpu_ready !== 1'b1 || cpu_data !== 32'hCAFEF00D) begin errors++; $display("FAIL clean_fill: got rd=%0d %b/%h want 1 1/cafef00d", rd, cpu_ready, cpu_data); end
    @(negedge clk);
    flush = 1'b1;
    exp_hits = 9;
    #1;
    checks++; if (cpu_ready !== 1'b0 || cpu_data !== 32'h0 || mem_rd !== 1'b0) begin errors++; $display("FAIL idle_flush: got %b/%h rd=%b want 0/0 rd=0", cpu_ready, cpu_data, mem_rd); end
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1;
    #1;
    exp_miss = 7;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL miss_after_flush: got %b want 0", cpu_ready); end
    run_fill(16'h0100, 32'h12345678, 1, rd, rdy, bad);
    checks++; if (cpu_ready !== 1'b1 || cpu_data !== 32'h12345678) begin errors++; $display("FAIL refill_after_flush: got %b/%h want 1/12345678", cpu_ready, cpu_data); end
    @(negedge clk);
    cpu_req = 1'b0;
    exp_hits = 10;
    #1;
    exp_h = STATS ? 16'(exp_hits) : 16'h0;
    exp_m = STATS ? 16'(exp_miss) : 16'h0;
    checks++; if (hit_count !== exp_h || miss_count !== exp_m) begin errors++; $display("FAIL flush_counts: got %h/%h want %h/%h", hit_count, miss_count, exp_h, exp_m); end
  endtask

  task automatic test_reset_mid_fill();
    int rd, rdy, bad;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0200;
    @(negedge clk);
    #1;
    checks++; if (mem_rd !== 1'b1) begin errors++; $display("FAIL pre_reset_fill: got %b want 1", mem_rd); end
    rst = 1'b0;
    #1;
    exp_hits = 0; exp_miss = 0;
    checks++; if (mem_rd !== 1'b0 || mem_addr !== 16'h0 || cpu_ready !== 1'b0) begin errors++; $display("FAIL async_reset: got rd=%b addr=%h ready=%b want 0/0/0", mem_rd, mem_addr, cpu_ready); end
    checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin errors++; $display("FAIL reset_clears_counts: got %h/%h want 0/0", hit_count, miss_count); end
    @(negedge clk);
    rst = 1'b1; cpu_req = 1'b0; mem_ready = 1'b1; mem_data = 32'hBAD0BAD0;
    @(negedge clk);
    mem_ready = 1'b0; mem_data = '0;
    #1;
    checks++; if (mem_rd !== 1'b0 || miss_count !== 16'h0) begin errors++; $display("FAIL stray_ready: got rd=%b miss=%h want 0/0", mem_rd, miss_count); end
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h0100;
    #1;
    checks++; if (cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_invalidates: got %b want 0", cpu_ready); end
    run_fill(16'h0100, 32'h12345678, 1, rd, rdy, bad);
    exp_miss = 1;
    exp_m = STATS ? 16'(exp_miss) : 16'h0;
    checks++; if (rd !== 1 || cpu_ready !== 1'b1 || miss_count !== exp_m) begin errors++; $display("FAIL post_reset_fill: got rd=%0d ready=%b miss=%h want 1/1/%h", rd, cpu_ready, miss_count, exp_m); end
  endtask

  task automatic test_stats();
`ifdef ICACHE_STATS_EN
    repeat (70000) @(negedge clk);
    #1;
    checks++; if (hit_count !== 16'hFFFF) begin errors++; $display("FAIL hit_saturate: got %h want ffff", hit_count); end
    @(negedge clk);
    #1;
    checks++; if (hit_count !== 16'hFFFF || cpu_ready !== 1'b1) begin errors++; $display("FAIL hit_stays_sat: got %h ready=%b want ffff/1", hit_count, cpu_ready); end
`else
    repeat (20) @(negedge clk);
    #1;
    checks++; if (cpu_ready !== 1'b1) begin errors++; $display("FAIL stats_off_hit: got %b want 1", cpu_ready); end
    checks++; if (hit_count !== 16'h0 || miss_count !== 16'h0) begin errors++; $display("FAIL stats_off_zero: got %h/%h want 0/0", hit_count, miss_count); end
`endif
    @(negedge clk);
    cpu_req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_miss_fill();
    test_hit();
    test_conflict();
    test_flush();
    test_reset_mid_fill();
    test_stats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
